// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier.
// Holds the funct3 encodings of the M-extension multiply variants and the
// control word that travels down the pipe next to the partial products.
package mul_pkg;

    localparam logic [2:0] MUL_LO  = 3'b000;
    localparam logic [2:0] MUL_H   = 3'b001;
    localparam logic [2:0] MUL_HSU = 3'b010;
    localparam logic [2:0] MUL_HU  = 3'b011;

    typedef struct packed {
        logic [2:0] funct3;
        logic       mulw;
        logic       valid;
    } mul_ctrl_t;

endpackage

// File: rtl/mul_pipe_reg.sv
// One pipeline stage register of the multiplier.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   en              advance enable (low holds the stage)
//   clr             synchronous clear of data and control (beats en)
//   d_data, d_ctrl  stage inputs
//   q_data, q_ctrl  registered stage outputs
module mul_pipe_reg
    import mul_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] d_data,
    input  mul_ctrl_t     d_ctrl,
    output logic [DW-1:0] q_data,
    output mul_ctrl_t     q_ctrl
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q_data <= '0;
            q_ctrl <= '0;
        end else if (en) begin
            q_data <= d_data;
            q_ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU, MULW).
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   StallM, FlushM      hold / invalidate all stages (flush wins)
//   ValidE              a multiply is issued this cycle
//   ForwardedSrcAE/BE   operands after forwarding
//   Funct3E, MulWE      operation select
//   ProdM               2*XLEN product leaving the last stage
//   ResultM             architecturally selected XLEN result
//   ValidM              last stage holds a live operation
//   BusyM               any stage holds a live operation
module mul_pipe
    import mul_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter bit W64    = (XLEN == 64)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic              ValidE,
    input  logic [XLEN-1:0]   ForwardedSrcAE,
    input  logic [XLEN-1:0]   ForwardedSrcBE,
    input  logic [2:0]        Funct3E,
    input  logic              MulWE,
    output logic [2*XLEN-1:0] ProdM,
    output logic [XLEN-1:0]   ResultM,
    output logic              ValidM,
    output logic              BusyM
);

    localparam int PW = 2 * XLEN;
    localparam int H  = XLEN / 2;
    localparam int DW = 2 * PW;

    logic            a_sgn, b_sgn;
    logic [XLEN:0]   sa, sb;
    logic [PW-1:0]   a_wide, blo_wide, bhi_wide;
    logic [PW-1:0]   pp_lo, pp_hi;
    logic [DW-1:0]   st0_data;
    mul_ctrl_t       st0_ctrl;

    // Unknown funct3 codes fall into the signed/signed (MUL) case.
    always_comb begin
        a_sgn = (Funct3E != MUL_HU);
        b_sgn = (Funct3E != MUL_HSU) && (Funct3E != MUL_HU);
    end

    assign sa = {a_sgn & ForwardedSrcAE[XLEN-1], ForwardedSrcAE};
    assign sb = {b_sgn & ForwardedSrcBE[XLEN-1], ForwardedSrcBE};

    // B is split into an unsigned low half and a signed high half so the two
    // partial products carry the sign correction themselves. Everything is
    // sign-extended to PW bits, so plain modular multiplication gives the
    // signed product truncated to PW bits.
    assign a_wide   = {{(PW-XLEN-1){sa[XLEN]}}, sa};
    assign blo_wide = {{(PW-H){1'b0}}, sb[H-1:0]};
    assign bhi_wide = {{(PW-(XLEN-H+1)){sb[XLEN]}}, sb[XLEN:H]};

    assign pp_lo = a_wide * blo_wide;
    assign pp_hi = (a_wide * bhi_wide) << H;

    assign st0_data        = {pp_hi, pp_lo};
    assign st0_ctrl.funct3 = Funct3E;
    assign st0_ctrl.mulw   = MulWE & W64;
    assign st0_ctrl.valid  = ValidE;

    logic [DW-1:0] q_data [STAGES];
    mul_ctrl_t     q_ctrl [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            mul_pipe_reg #(.DW(DW)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (~StallM),
                .clr   (FlushM),
                .d_data(st0_data),
                .d_ctrl(st0_ctrl),
                .q_data(q_data[s]),
                .q_ctrl(q_ctrl[s])
            );
        end else begin : g_next
            mul_pipe_reg #(.DW(DW)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (~StallM),
                .clr   (FlushM),
                .d_data(q_data[s-1]),
                .d_ctrl(q_ctrl[s-1]),
                .q_data(q_data[s]),
                .q_ctrl(q_ctrl[s])
            );
        end
    end

    // Final carry-propagate add of the two carried partial products.
    logic [DW-1:0] last_data;
    mul_ctrl_t     last_ctrl;

    assign last_data = q_data[STAGES-1];
    assign last_ctrl = q_ctrl[STAGES-1];
    assign ProdM     = last_data[PW-1:0] + last_data[DW-1:PW];
    assign ValidM    = last_ctrl.valid;

    always_comb begin
        ResultM = ProdM[XLEN-1:0];
        if (last_ctrl.mulw) begin
            ResultM = XLEN'($signed(ProdM[31:0]));
        end else if (last_ctrl.funct3 == MUL_H || last_ctrl.funct3 == MUL_HSU ||
                     last_ctrl.funct3 == MUL_HU) begin
            ResultM = ProdM[PW-1:XLEN];
        end
    end

    always_comb begin
        BusyM = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            BusyM = BusyM | q_ctrl[i].valid;
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
module tb_mul_pipe;

    localparam int XLEN   = 64;
    localparam int STAGES = 2;
    localparam int NV     = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              StallM, FlushM, ValidE, MulWE;
    logic [XLEN-1:0]   ForwardedSrcAE, ForwardedSrcBE;
    logic [2:0]        Funct3E;
    logic [2*XLEN-1:0] ProdM;
    logic [XLEN-1:0]   ResultM;
    logic              ValidM, BusyM;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [2:0]   f3;
        logic         w;
        logic [127:0] prod;
        logic [63:0]  res;
    } vec_t;

    vec_t vecs [NV];

    mul_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
        .clk           (clk),
        .reset         (reset),
        .StallM        (StallM),
        .FlushM        (FlushM),
        .ValidE        (ValidE),
        .ForwardedSrcAE(ForwardedSrcAE),
        .ForwardedSrcBE(ForwardedSrcBE),
        .Funct3E       (Funct3E),
        .MulWE         (MulWE),
        .ProdM         (ProdM),
        .ResultM       (ResultM),
        .ValidM        (ValidM),
        .BusyM         (BusyM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] f3, input logic w);
        ValidE         = v;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        Funct3E        = f3;
        MulWE          = w;
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_valid"}, 128'(ValidM), 128'd0);
        check({tag, "_busy"},  128'(BusyM),  128'd0);
        check({tag, "_prod"},  ProdM,        128'd0);
        check({tag, "_res"},   128'(ResultM), 128'd0);
    endtask

    initial begin
        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1'b0,
                     128'h1, 64'h0};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b0,
                     128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b0,
                     128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{64'h0000_0000_4000_0000, 64'h2, 3'b000, 1'b1,
                     128'h8000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[4]  = '{64'h3, 64'h5, 3'b000, 1'b0, 128'd15, 64'd15};
        vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 3'b000, 1'b0,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b001, 1'b0,
                     128'h4000_0000_0000_0000_0000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[7]  = '{64'h8000_0000_0000_0000, 64'h2, 3'b011, 1'b0,
                     128'h1_0000_0000_0000_0000, 64'h1};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 3'b010, 1'b0,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b0,
                     128'h1_FFFF_FFFF_FFFF_FFFE, 64'h1};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0,
                     128'h1, 64'h1};
        vecs[11] = '{64'h1_0000_0003, 64'h5, 3'b000, 1'b1,
                     128'h5_0000_000F, 64'hF};
        vecs[12] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b000, 1'b1,
                     128'hFFFF_FFFE_0000_0001, 64'h1};
        vecs[13] = '{64'h1_0000_0000, 64'h1_0000_0000, 3'b000, 1'b0,
                     128'h1_0000_0000_0000_0000, 64'h0};

        reset  = 1'b1;
        StallM = 1'b0;
        FlushM = 1'b0;
        issue(1'b0, 64'h0, 64'h0, 3'b000, 1'b0);
        step();
        step();
        check_clear("reset");
        reset = 1'b0;
        step();
        check_clear("idle");

        // Back-to-back stream; each result must surface exactly STAGES edges later.
        for (int i = 0; i < NV + STAGES - 1; i++) begin
            if (i < NV) issue(1'b1, vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].w);
            else        issue(1'b0, 64'h0, 64'h0, 3'b000, 1'b0);
            step();
            if (i >= STAGES - 1) begin
                check($sformatf("vec%0d_valid", i - STAGES + 1), 128'(ValidM), 128'd1);
                check($sformatf("vec%0d_prod",  i - STAGES + 1), ProdM, vecs[i - STAGES + 1].prod);
                check($sformatf("vec%0d_res",   i - STAGES + 1), 128'(ResultM),
                      128'(vecs[i - STAGES + 1].res));
            end else begin
                check("lat_first_valid", 128'(ValidM), 128'd0);
            end
        end
        issue(1'b0, 64'h0, 64'h0, 3'b000, 1'b0);
        step();
        check("drain_valid", 128'(ValidM), 128'd0);
        check("drain_busy",  128'(BusyM),  128'd0);

        // Stall: 7*6 sits in stage 1 while new requests are ignored.
        issue(1'b1, 64'd7, 64'd6, 3'b000, 1'b0);
        step();
        check("st_issue_busy",  128'(BusyM),  128'd1);
        check("st_issue_valid", 128'(ValidM), 128'd0);
        StallM = 1'b1;
        issue(1'b1, 64'd9, 64'd9, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("st_hold%0d_valid", k), 128'(ValidM), 128'd0);
            check($sformatf("st_hold%0d_busy", k),  128'(BusyM),  128'd1);
        end
        StallM = 1'b0;
        issue(1'b0, 64'h0, 64'h0, 3'b000, 1'b0);
        step();
        check("st_rel_valid", 128'(ValidM),  128'd1);
        check("st_rel_res",   128'(ResultM), 128'd42);
        check("st_rel_prod",  ProdM,         128'd42);
        StallM = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("st_out%0d_valid", k), 128'(ValidM),  128'd1);
            check($sformatf("st_out%0d_res", k),   128'(ResultM), 128'd42);
        end
        StallM = 1'b0;
        step();
        check("st_once_valid", 128'(ValidM), 128'd0);
        check("st_once_busy",  128'(BusyM),  128'd0);

        // Flush together with stall: flush wins and clears data too.
        issue(1'b1, 64'd5, 64'd5, 3'b000, 1'b0);
        step();
        issue(1'b1, 64'd9, 64'd9, 3'b000, 1'b0);
        step();
        check("fl_pre_res", 128'(ResultM), 128'd25);
        FlushM = 1'b1;
        StallM = 1'b1;
        issue(1'b1, 64'd3, 64'd3, 3'b000, 1'b0);
        step();
        check_clear("flush");
        FlushM = 1'b0;
        StallM = 1'b0;
        issue(1'b0, 64'h0, 64'h0, 3'b000, 1'b0);
        step();
        check_clear("flush_after");

        // Reset mid-stream.
        issue(1'b1, 64'd7, 64'd6, 3'b011, 1'b0);
        step();
        issue(1'b1, 64'd9, 64'd9, 3'b000, 1'b0);
        step();
        check("rs_pre_valid", 128'(ValidM), 128'd1);
        reset = 1'b1;
        step();
        check_clear("midreset");
        reset = 1'b0;
        issue(1'b0, 64'h0, 64'h0, 3'b000, 1'b0);
        step();
        check_clear("post_reset0");
        step();
        check_clear("post_reset1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
